// File: rtl/rtds_pkg.sv
// Shared types and default constants for the ready-to-drive sequencer.
package rtds_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SOUND = 2'd1,
      DRIVE = 2'd2,
      FAULT = 2'd3
   } rtds_state_t;

   localparam int DEF_NUM_BSE         = 2;
   localparam int DEF_ADC_W           = 12;
   localparam int DEF_BRAKE_ON        = 200;
   localparam int DEF_BRAKE_OFF       = 150;
   localparam int DEF_BSE_MIN         = 100;
   localparam int DEF_BSE_MAX         = 3900;
   localparam int DEF_SOUND_CYCLES    = 3000;
   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_FAULT_CYCLES    = 100;

   // Width of a counter that must be able to hold the value n.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/rtds_debounce.sv
// Button synchroniser, debounce filter and rising-edge pulse for dash inputs.
module rtds_debounce
   import rtds_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button,
   output logic pulse
);

   localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_meta;
   logic          sync_out;
   logic          armed;
   logic          level;
   logic          level_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= 1'b0;
         sync_out  <= 1'b0;
      end else begin
         sync_meta <= button;
         sync_out  <= sync_meta;
      end
   end

   // Until the button has been seen released for a full debounce window the
   // filter stays disarmed, so a button held through reset never fires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed   <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
      end else begin
         level_d <= level;
         if (!armed) begin
            if (sync_out) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               armed <= 1'b1;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else if (sync_out != level) begin
            if (cnt == CNT_LAST) begin
               level <= sync_out;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign pulse = level & ~level_d;

endmodule

// File: rtl/rtds_ctrl.sv
// Ready-to-drive sequencer: brake hysteresis, start debounce, sound timer, FSM.
// Optional sensor-plausibility fault latch is enabled by defining BSE_PLAUSIBILITY_EN.
module rtds_ctrl
   import rtds_pkg::*;
#(
   parameter int NUM_BSE         = DEF_NUM_BSE,
   parameter int ADC_W           = DEF_ADC_W,
   parameter int BRAKE_ON        = DEF_BRAKE_ON,
   parameter int BRAKE_OFF       = DEF_BRAKE_OFF,
   parameter int BSE_MIN         = DEF_BSE_MIN,
   parameter int BSE_MAX         = DEF_BSE_MAX,
   parameter int SOUND_CYCLES    = DEF_SOUND_CYCLES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int FAULT_CYCLES    = DEF_FAULT_CYCLES
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sdc_final,
   input  logic [NUM_BSE*ADC_W-1:0] bse,
   input  logic                     start_button,
   output logic                     brake_light,
   output logic                     speaker,
   output logic                     ready_to_drive,
   output logic                     bse_fault,
   output logic [1:0]               state
);

   localparam int                SCW        = cnt_width(SOUND_CYCLES);
   localparam logic [SCW-1:0]    SOUND_LAST = SCW'(SOUND_CYCLES - 1);
   localparam logic [ADC_W-1:0]  TH_ON      = ADC_W'(BRAKE_ON);
   localparam logic [ADC_W-1:0]  TH_OFF     = ADC_W'(BRAKE_OFF);

   if (NUM_BSE < 1 || NUM_BSE > 4 || BRAKE_OFF > BRAKE_ON || BSE_MIN > BSE_MAX ||
       SOUND_CYCLES < 1 || DEBOUNCE_CYCLES < 1 || FAULT_CYCLES < 1) begin : g_bad_params
      $error("rtds_ctrl: invalid parameter set");
   end

   rtds_state_t    cur_state;
   rtds_state_t    state_next;
   logic [SCW-1:0] sound_cnt;
   logic           start_evt;
   logic           brake_pressed;
   logic           any_on;
   logic           all_off;
   logic           fault_enter;
   logic           fault_release;

   rtds_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_start_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .button (start_button),
      .pulse  (start_evt)
   );

   always_comb begin
      any_on  = 1'b0;
      all_off = 1'b1;
      for (int i = 0; i < NUM_BSE; i++) begin
         if (bse[i*ADC_W +: ADC_W] > TH_ON) begin
            any_on = 1'b1;
         end
         if (bse[i*ADC_W +: ADC_W] > TH_OFF) begin
            all_off = 1'b0;
         end
      end
   end

   // Hysteresis flop followed by the registered, active-low light driver.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         brake_pressed <= 1'b0;
         brake_light   <= 1'b1;
      end else begin
         brake_light <= ~brake_pressed;
         if (any_on) begin
            brake_pressed <= 1'b1;
         end else if (all_off) begin
            brake_pressed <= 1'b0;
         end
      end
   end

`ifdef BSE_PLAUSIBILITY_EN
   localparam int               FCW        = cnt_width(FAULT_CYCLES);
   localparam logic [FCW-1:0]   FAULT_LAST = FCW'(FAULT_CYCLES - 1);
   localparam logic [ADC_W-1:0] LIM_MIN    = ADC_W'(BSE_MIN);
   localparam logic [ADC_W-1:0] LIM_MAX    = ADC_W'(BSE_MAX);
   localparam bit               HAS_FAULT  = 1'b1;

   logic           implausible;
   logic [FCW-1:0] fault_cnt;

   always_comb begin
      implausible = 1'b0;
      for (int i = 0; i < NUM_BSE; i++) begin
         if (bse[i*ADC_W +: ADC_W] < LIM_MIN || bse[i*ADC_W +: ADC_W] > LIM_MAX) begin
            implausible = 1'b1;
         end
      end
   end

   assign fault_enter   = implausible && (fault_cnt == FAULT_LAST) && (cur_state != FAULT);
   assign fault_release = !implausible && (fault_cnt == FAULT_LAST) && (cur_state == FAULT);

   // Outside FAULT this counts consecutive bad cycles; inside it counts good ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_cnt <= '0;
      end else if (fault_enter || fault_release) begin
         fault_cnt <= '0;
      end else if ((cur_state == FAULT) ? !implausible : implausible) begin
         fault_cnt <= fault_cnt + 1'b1;
      end else begin
         fault_cnt <= '0;
      end
   end
`else
   localparam bit HAS_FAULT = 1'b0;

   assign fault_enter   = 1'b0;
   assign fault_release = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state <= IDLE;
      end else begin
         cur_state <= state_next;
      end
   end

   always_comb begin
      state_next = cur_state;
      case (cur_state)
         IDLE: begin
            if (start_evt && brake_pressed && sdc_final) begin
               state_next = SOUND;
            end
         end
         SOUND: begin
            if (!sdc_final) begin
               state_next = IDLE;
            end else if (sound_cnt == SOUND_LAST) begin
               state_next = DRIVE;
            end
         end
         DRIVE: begin
            if (!sdc_final) begin
               state_next = IDLE;
            end
         end
         FAULT: begin
            if (fault_release) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (fault_enter) begin
         state_next = FAULT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sound_cnt <= '0;
      end else if (cur_state == SOUND && state_next == SOUND) begin
         sound_cnt <= sound_cnt + 1'b1;
      end else begin
         sound_cnt <= '0;
      end
   end

   always_comb begin
      speaker        = 1'b1;
      ready_to_drive = 1'b0;
      bse_fault      = 1'b0;
      case (cur_state)
         SOUND:   speaker        = 1'b0;
         DRIVE:   ready_to_drive = 1'b1;
         FAULT:   bse_fault      = HAS_FAULT;
         default: ;
      endcase
   end

   assign state = cur_state;

endmodule

// File: tb/tb_rtds_ctrl.sv
// Scoreboard bench for rtds_ctrl: directed scenarios plus random stimulus,
// checked every cycle against a timestamp-based behavioural model.
module tb_rtds_ctrl;

   localparam int NUM_BSE         = 2;
   localparam int ADC_W           = 12;
   localparam int BRAKE_ON        = 200;
   localparam int BRAKE_OFF       = 150;
   localparam int BSE_MIN         = 100;
   localparam int BSE_MAX         = 3900;
   localparam int SOUND_CYCLES    = 3000;
   localparam int DEBOUNCE_CYCLES = 16;
   localparam int FAULT_CYCLES    = 100;

   localparam int S_IDLE  = 0;
   localparam int S_SOUND = 1;
   localparam int S_DRIVE = 2;
   localparam int S_FAULT = 3;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     sdc_final = 1'b0;
   logic                     start_button = 1'b0;
   logic [NUM_BSE*ADC_W-1:0] bse = '0;
   logic                     brake_light;
   logic                     speaker;
   logic                     ready_to_drive;
   logic                     bse_fault;
   logic [1:0]               state;

   rtds_ctrl #(
      .NUM_BSE         (NUM_BSE),
      .ADC_W           (ADC_W),
      .BRAKE_ON        (BRAKE_ON),
      .BRAKE_OFF       (BRAKE_OFF),
      .BSE_MIN         (BSE_MIN),
      .BSE_MAX         (BSE_MAX),
      .SOUND_CYCLES    (SOUND_CYCLES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .FAULT_CYCLES    (FAULT_CYCLES)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .sdc_final      (sdc_final),
      .bse            (bse),
      .start_button   (start_button),
      .brake_light    (brake_light),
      .speaker        (speaker),
      .ready_to_drive (ready_to_drive),
      .bse_fault      (bse_fault),
      .state          (state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] st;
      logic       spk;
      logic       rtd;
      logic       bl;
      logic       flt;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: edge index plus timestamps of the last notable events.
   int m_st;
   int cyc = 0;
   int sound_start, fault_entry, last_good, last_bad, last_exit;
   bit m_bp, m_bl, m_level, m_armed, m_evt;
   bit btn_q[$];
   bit hist[$];

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic exp_t expNow();
      return {2'(m_st), (m_st != S_SOUND), (m_st == S_DRIVE), m_bl, (m_st == S_FAULT)};
   endfunction

   task automatic modelReset();
      cyc++;
      m_st = S_IDLE;
      m_bp = 1'b0;
      m_bl = 1'b1;
      m_level = 1'b0;
      m_armed = 1'b0;
      m_evt = 1'b0;
      btn_q = '{1'b0, 1'b0};
      hist.delete();
      sound_start = cyc;
      fault_entry = cyc;
      last_good = cyc;
      last_bad = cyc;
      last_exit = cyc;
   endtask

   task automatic modelStep();
      int nxt;
      int v;
      bit any_on, all_off, plaus, all_diff, all_zero, s;
      cyc++;
      any_on = 1'b0;
      all_off = 1'b1;
      plaus = 1'b1;
      for (int i = 0; i < NUM_BSE; i++) begin
         v = int'(bse[i*ADC_W +: ADC_W]);
         if (v > BRAKE_ON) any_on = 1'b1;
         if (v > BRAKE_OFF) all_off = 1'b0;
         if (v < BSE_MIN || v > BSE_MAX) plaus = 1'b0;
      end
      if (plaus) last_good = cyc;
      else last_bad = cyc;

      nxt = m_st;
      case (m_st)
         S_IDLE:  if (m_evt && m_bp && sdc_final) nxt = S_SOUND;
         S_SOUND: if (!sdc_final) nxt = S_IDLE;
                  else if (cyc - sound_start == SOUND_CYCLES) nxt = S_DRIVE;
         S_DRIVE: if (!sdc_final) nxt = S_IDLE;
         default: if (cyc - max2(last_bad, fault_entry) >= FAULT_CYCLES) nxt = S_IDLE;
      endcase
`ifdef BSE_PLAUSIBILITY_EN
      if (m_st != S_FAULT && cyc - max2(last_good, last_exit) >= FAULT_CYCLES) nxt = S_FAULT;
`endif
      if (nxt == S_SOUND && m_st != S_SOUND) sound_start = cyc;
      if (nxt == S_FAULT && m_st != S_FAULT) fault_entry = cyc;
      if (m_st == S_FAULT && nxt != S_FAULT) last_exit = cyc;

      m_bl = !m_bp;
      if (any_on) m_bp = 1'b1;
      else if (all_off) m_bp = 1'b0;

      // Debounced level flips once the last DEBOUNCE_CYCLES synchronised samples all disagree.
      btn_q.push_back(start_button);
      s = btn_q.pop_front();
      hist.push_back(s);
      if (hist.size() > DEBOUNCE_CYCLES) void'(hist.pop_front());
      m_evt = 1'b0;
      if (hist.size() == DEBOUNCE_CYCLES) begin
         all_diff = 1'b1;
         all_zero = 1'b1;
         foreach (hist[i]) begin
            if (hist[i] == m_level) all_diff = 1'b0;
            if (hist[i]) all_zero = 1'b0;
         end
         if (!m_armed) begin
            if (all_zero) m_armed = 1'b1;
         end else if (all_diff) begin
            m_level = !m_level;
            m_evt = m_level;
         end
      end
      m_st = nxt;
   endtask

   task automatic applyReset(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         rst_n = 1'b0;
         modelReset();
         sb_q.push_back(expNow());
      end
   endtask

   task automatic applyStimulus(input bit sdc, input bit btn, input int ch0, input int ch1, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         rst_n = 1'b1;
         sdc_final = sdc;
         start_button = btn;
         bse[0 +: ADC_W] = ADC_W'(ch0);
         bse[ADC_W +: ADC_W] = ADC_W'(ch1);
         modelStep();
         sb_q.push_back(expNow());
      end
   endtask

   task automatic checkOutput(input exp_t e);
      exp_t a;
      a = {state, speaker, ready_to_drive, brake_light, bse_fault};
      checks++;
      if (a !== e) begin
         errors++;
         $display("[TB] FAIL outputs t=%0t actual state=%0d spk=%b rtd=%b bl=%b flt=%b required state=%0d spk=%b rtd=%b bl=%b flt=%b",
                  $time, a.st, a.spk, a.rtd, a.bl, a.flt, e.st, e.spk, e.rtd, e.bl, e.flt);
      end
   endtask

   function automatic int pickCh();
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) return $urandom_range(3901, 4095);
      if (r == 1) return $urandom_range(0, 99);
      return $urandom_range(120, 260);
   endfunction

   // Monitor: pops one expectation per clock and cross-checks the sound length.
   int spk_run = 0;
   int last_run = 0;
   bit rtd_prev = 1'b0;
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checkOutput(e);
         end
         if (speaker === 1'b0) begin
            spk_run++;
         end else begin
            if (spk_run != 0) last_run = spk_run;
            spk_run = 0;
         end
         if (ready_to_drive === 1'b1 && !rtd_prev) begin
            checks++;
            if (last_run != SOUND_CYCLES) begin
               errors++;
               $display("[TB] FAIL sound_length actual=%0d required=%0d", last_run, SOUND_CYCLES);
            end
         end
         rtd_prev = (ready_to_drive === 1'b1);
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int w;
      bit sdc, btn;
      int c0, c1, n;

      // Button held through reset and stuck afterwards must not start anything.
      start_button = 1'b1;
      sdc_final = 1'b1;
      bse[0 +: ADC_W] = ADC_W'(300);
      bse[ADC_W +: ADC_W] = ADC_W'(300);
      applyReset(3);
      applyStimulus(1, 1, 300, 300, 40);
      applyStimulus(1, 0, 300, 300, 30);

      // Full start sequence, then brake release / second press in DRIVE.
      applyStimulus(1, 1, 300, 300, 20);
      applyStimulus(1, 0, 300, 300, 3100);
      applyStimulus(1, 0, 100, 100, 20);
      applyStimulus(1, 1, 100, 100, 20);
      applyStimulus(0, 0, 100, 100, 5);

      // Brake off: start press ignored.
      applyStimulus(1, 0, 100, 100, 30);
      applyStimulus(1, 1, 100, 100, 25);
      applyStimulus(1, 0, 100, 100, 30);

      // Abort mid-sound, then a complete restart.
      applyStimulus(1, 1, 300, 300, 20);
      applyStimulus(1, 0, 300, 300, 1501);
      applyStimulus(0, 0, 300, 300, 3);
      applyStimulus(1, 0, 300, 300, 30);
      applyStimulus(1, 1, 300, 300, 20);
      applyStimulus(1, 0, 300, 300, 3100);
      applyStimulus(0, 0, 300, 300, 3);

      // Bouncing button.
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1, 1, 300, 300, 5);
         applyStimulus(1, 0, 300, 300, 5);
      end

      // Hysteresis ramp.
      applyStimulus(1, 0, 140, 140, 10);
      applyStimulus(1, 0, 210, 140, 10);
      applyStimulus(1, 0, 160, 140, 10);
      applyStimulus(1, 0, 150, 150, 10);

      // Asynchronous reset during the sound.
      applyStimulus(1, 0, 300, 300, 20);
      applyStimulus(1, 1, 300, 300, 20);
      applyStimulus(1, 0, 300, 300, 500);
      applyReset(2);
      applyStimulus(1, 0, 300, 300, 30);

`ifdef BSE_PLAUSIBILITY_EN
      applyStimulus(1, 1, 300, 300, 20);
      applyStimulus(1, 0, 300, 300, 3100);
      applyStimulus(1, 0, 300, 4000, 120);
      applyStimulus(1, 0, 300, 300, 120);
`endif

      for (int b = 0; b < 300; b++) begin
         sdc = ($urandom_range(0, 19) != 0);
         btn = 1'($urandom_range(0, 1));
         c0 = pickCh();
         c1 = pickCh();
         n = $urandom_range(1, 40);
         applyStimulus(sdc, btn, c0, c1, n);
      end

      w = 0;
      while (sb_q.size() != 0 && w < 10) begin
         @(posedge clk);
         #2;
         w++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain actual=%0d pending required=0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rtds_ctrl.md
# rtds_ctrl

Parametrised ready-to-drive sequencer for the vehicle control FPGA, superseding the single-sensor RTDS block. It samples NUM_BSE brake-pressure channels with hysteresis, debounces the dash start button, and plays the ready-to-drive sound for a fixed time before asserting ready_to_drive. It also drives the brake light and, optionally, latches a sensor-plausibility fault. It sits between the ADC front end, the shutdown-circuit (SDC) monitor and the inverter-enable logic.

## Interface
- NUM_BSE, 2, number of brake-pressure channels (1..4)
- ADC_W, 12, ADC sample width
- BRAKE_ON, 200, brake-pressed threshold (strictly greater than)
- BRAKE_OFF, 150, brake-released threshold (less than or equal); must be ≤ BRAKE_ON
- BSE_MIN, 100, lowest plausible sample
- BSE_MAX, 3900, highest plausible sample
- SOUND_CYCLES, 3000, cycles the speaker is on; ≥ 1
- DEBOUNCE_CYCLES, 16, consecutive stable samples to accept a start_button level; ≥ 1
- FAULT_CYCLES, 100, consecutive implausible cycles to enter FAULT, and consecutive plausible cycles to leave it; ≥ 1

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- sdc_final  in  1  shutdown circuit closed (active high)
- bse  in  NUM_BSE*ADC_W  packed samples; channel i is bits [i*ADC_W +: ADC_W]
- start_button  in  1  raw dash button (active high, asynchronous to clk)
- brake_light  out  1  active low
- speaker  out  1  active low
- ready_to_drive  out  1  active high
- bse_fault  out  1  high while in FAULT
- state  out  2  current state encoding, for telemetry

## Operation
- Reset values: brake_light=1, speaker=1, ready_to_drive=0, bse_fault=0, state=IDLE. All counters are 0, the debounced button is 0 and brake_pressed is 0.
- Start-button debounce: two-flop synchroniser, then a counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronised samples differ from it. start_evt is a one-cycle pulse on a 0→1 edge of the debounced level. A button held through reset or stuck high never produces start_evt.
- Brake hysteresis:
  - brake_pressed sets when any channel > BRAKE_ON.
  - brake_pressed clears when all channels ≤ BRAKE_OFF.
  - Otherwise it holds.
  - brake_light = ~brake_pressed, registered.
- State machine (Moore; speaker and ready_to_drive are decoded from the state register only):
  - IDLE: go to SOUND when start_evt && brake_pressed && sdc_final are all true in the same cycle.
  - SOUND: speaker=0 and the sound counter increments. Go to DRIVE when the counter equals SOUND_CYCLES-1. Go to IDLE if sdc_final=0. The sdc_final check wins over completion in the same cycle.
  - DRIVE: ready_to_drive=1. Go to IDLE when sdc_final=0. Releasing the brake or pressing start again has no effect.
  - FAULT: speaker=1, ready_to_drive=0, bse_fault=1. Go to IDLE after FAULT_CYCLES consecutive plausible cycles. Re-entering DRIVE needs a fresh start sequence.
- The sound counter clears in every state other than SOUND and is sized $clog2(SOUND_CYCLES+1). It never wraps.
- Reset asserted mid-sequence returns to IDLE immediately with all outputs at reset values.

## Timing
- start_button → start_evt: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles.
- start_evt cycle → state=SOUND on the next edge. speaker is low for exactly SOUND_CYCLES cycles, then ready_to_drive rises on the following edge with no gap.
- sdc_final low → state=IDLE (ready_to_drive=0, speaker=1) on the next edge.
- bse crossing → brake_light change: 2 cycles (hysteresis flop, then output flop).
- Implausibility → FAULT on the edge after the FAULT_CYCLES-th consecutive bad cycle.

## Configuration
- BSE_PLAUSIBILITY_EN defined:
  - A cycle is implausible if any channel is < BSE_MIN or > BSE_MAX.
  - FAULT is entered from any state; FAULT takes priority over sdc_final handling.
  - Out-of-range channels are still used for brake_pressed, so the brake light stays fail-safe.
- BSE_PLAUSIBILITY_EN undefined:
  - No range checks; fault counter removed.
  - bse_fault is tied to 0 and FAULT is unreachable.
  - All other behaviour is identical.

## Structure
- Package rtds_pkg:
  - rtds_state_t enum, 2-bit encoding IDLE=2'd0, SOUND=2'd1, DRIVE=2'd2, FAULT=2'd3. state outputs this encoding.
  - Default threshold constants.
- Sub-module rtds_debounce: synchroniser, debounce counter and rising-edge pulse, parameterised by DEBOUNCE_CYCLES. It is reused for other dash buttons.
- Top level contains the hysteresis logic, the plausibility counter, the FSM and the sound counter.

## Test plan
- bse={300,300}, sdc=1, start held 20 cycles → SOUND after 2+16+1 cycles; speaker low exactly 3000 cycles; ready_to_drive=1 on the next cycle.
- bse={100,100} (brake off), start pressed → stays IDLE; speaker stays 1.
- In SOUND at count 1500, sdc_final→0 → IDLE next cycle; speaker=1; re-pressing start restarts the full 3000-cycle sound.
- start bouncing 1/0 every 5 cycles for 100 cycles → no start_evt, state stays IDLE.
- bse ramps 140→210→160→150 → brake_light goes 0 two cycles after 210; stays 0 at 160; goes 1 two cycles after 150.
- BSE_PLAUSIBILITY_EN: in DRIVE, channel 1=4000 for 100 cycles → FAULT, ready_to_drive=0, bse_fault=1; after 100 plausible cycles → IDLE.
